// File: rtl/mem_wb_pkg.sv
// MEM->WB pipeline register shared types and default widths.
package mem_wb_pkg;

  localparam int unsigned DEFAULT_DATA_W     = 32;
  localparam int unsigned DEFAULT_REG_ADDR_W = 5;
  localparam int unsigned DEFAULT_ZERO_REG   = 0;

  // WB beat payload at the default widths
  typedef struct packed {
    logic [DEFAULT_DATA_W-1:0]     read_data;
    logic [DEFAULT_DATA_W-1:0]     alu_result;
    logic [DEFAULT_REG_ADDR_W-1:0] dest_reg;
    logic                          reg_write;
    logic                          mem_to_reg;
  } wb_payload_t;

endpackage : mem_wb_pkg

// File: rtl/mem_wb_pipe_reg_skid.sv
// Generic one-entry skid buffer with registered output stage and registered s_ready_o.
// Only compiled when MEM_WB_SKID_EN is defined.
`ifdef MEM_WB_SKID_EN
module pipe_skid_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [WIDTH-1:0] s_data_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o
);

  logic             m_valid_q, m_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept;
  logic             out_free;

  assign s_ready_o = ~skid_valid_q;
  assign accept    = s_valid_i & ~skid_valid_q & ~flush_i;
  assign out_free  = ~m_valid_q | m_ready_i;
  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;

  // Next state: skid drains first to keep order; a stalled accept parks in the skid
  always_comb begin
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (flush_i) begin
      m_valid_d    = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        m_data_d     = skid_q;
        m_valid_d    = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        m_data_d  = s_data_i;
        m_valid_d = 1'b1;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = s_data_i;
      skid_valid_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else begin
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
    end
  end

endmodule : pipe_skid_buf
`endif

// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register with valid/ready stall, synchronous flush, $0 write
// suppression, internal WB data mux and a forwarding tap.
// Optional: define MEM_WB_SKID_EN for a one-entry skid buffer (registered in_ready).
module mem_wb_pipe_reg
  import mem_wb_pkg::*;
#(
  parameter int unsigned DATA_W     = DEFAULT_DATA_W,
  parameter int unsigned REG_ADDR_W = DEFAULT_REG_ADDR_W,
  parameter int unsigned ZERO_REG   = DEFAULT_ZERO_REG
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_read_data,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [REG_ADDR_W-1:0] in_dest_reg,
  input  logic                  in_reg_write,
  input  logic                  in_mem_to_reg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_read_data,
  output logic [DATA_W-1:0]     out_alu_result,
  output logic [REG_ADDR_W-1:0] out_dest_reg,
  output logic                  out_reg_write,
  output logic                  out_mem_to_reg,
  output logic [DATA_W-1:0]     out_wb_data,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_reg,
  output logic [DATA_W-1:0]     fwd_data
);

  typedef struct packed {
    logic [DATA_W-1:0]     read_data;
    logic [DATA_W-1:0]     alu_result;
    logic [REG_ADDR_W-1:0] dest_reg;
    logic                  reg_write;
    logic                  mem_to_reg;
  } payload_t;

  localparam int unsigned PAY_W = $bits(payload_t);

  payload_t in_pay;
  payload_t out_pay;

  assign in_pay = '{read_data:  in_read_data,
                    alu_result: in_alu_result,
                    dest_reg:   in_dest_reg,
                    reg_write:  in_reg_write,
                    mem_to_reg: in_mem_to_reg};

`ifdef MEM_WB_SKID_EN
  logic             skid_ready;
  logic [PAY_W-1:0] out_pay_vec;

  pipe_skid_buf #(
    .WIDTH (PAY_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush),
    .s_valid_i (in_valid),
    .s_ready_o (skid_ready),
    .s_data_i  (PAY_W'(in_pay)),
    .m_valid_o (out_valid),
    .m_ready_i (out_ready),
    .m_data_o  (out_pay_vec)
  );

  assign in_ready = flush | skid_ready;
  assign out_pay  = payload_t'(out_pay_vec);
`else
  logic     valid_q, valid_d;
  payload_t pay_q, pay_d;
  logic     accept;

  assign in_ready  = flush | out_ready | ~valid_q;
  assign accept    = in_valid & in_ready & ~flush;
  assign out_valid = valid_q;
  assign out_pay   = pay_q;

  // Next state: flush wins, then load on accept, else drain when consumed
  always_comb begin
    valid_d = valid_q;
    pay_d   = pay_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      pay_d   = in_pay;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pay_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pay_q   <= pay_d;
    end
  end
`endif

  // WB mux, $0 gating and forwarding tap
  assign out_read_data  = out_pay.read_data;
  assign out_alu_result = out_pay.alu_result;
  assign out_dest_reg   = out_pay.dest_reg;
  assign out_mem_to_reg = out_pay.mem_to_reg;
  assign out_reg_write  = out_valid & out_pay.reg_write &
                          (out_pay.dest_reg != REG_ADDR_W'(ZERO_REG));
  assign out_wb_data    = out_pay.mem_to_reg ? out_pay.read_data : out_pay.alu_result;
  assign fwd_valid      = out_reg_write;
  assign fwd_reg        = out_dest_reg;
  assign fwd_data       = out_wb_data;

endmodule : mem_wb_pipe_reg

// File: tb/tb_mem_wb_pipe_reg.sv
// Self-checking bench for mem_wb_pipe_reg; model is a bounded FIFO of in-flight beats.
module tb_mem_wb_pipe_reg;
  import mem_wb_pkg::*;

`ifdef MEM_WB_SKID_EN
  localparam int unsigned CAP = 2;
`else
  localparam int unsigned CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_read_data = '0;
  logic [31:0] in_alu_result = '0;
  logic [4:0]  in_dest_reg = '0;
  logic        in_reg_write = 1'b0;
  logic        in_mem_to_reg = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_read_data;
  logic [31:0] out_alu_result;
  logic [4:0]  out_dest_reg;
  logic        out_reg_write;
  logic        out_mem_to_reg;
  logic [31:0] out_wb_data;
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;

  mem_wb_pipe_reg dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_read_data   (in_read_data),
    .in_alu_result  (in_alu_result),
    .in_dest_reg    (in_dest_reg),
    .in_reg_write   (in_reg_write),
    .in_mem_to_reg  (in_mem_to_reg),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_read_data  (out_read_data),
    .out_alu_result (out_alu_result),
    .out_dest_reg   (out_dest_reg),
    .out_reg_write  (out_reg_write),
    .out_mem_to_reg (out_mem_to_reg),
    .out_wb_data    (out_wb_data),
    .fwd_valid      (fwd_valid),
    .fwd_reg        (fwd_reg),
    .fwd_data       (fwd_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  wb_payload_t q[$];

  typedef struct {
    logic        fl;
    logic        iv;
    wb_payload_t p;
    logic        ev;
    logic [31:0] ewb;
    logic        erw;
    logic [4:0]  edst;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic wb_payload_t mk(input logic [31:0] rd, input logic [31:0] alu,
                                     input logic [4:0] dst, input logic rw, input logic m2r);
    wb_payload_t p;
    p.read_data  = rd;
    p.alu_result = alu;
    p.dest_reg   = dst;
    p.reg_write  = rw;
    p.mem_to_reg = m2r;
    return p;
  endfunction

  // Model: accept when flushing, when there is room, or (no skid) when the held beat leaves
  function automatic logic exp_in_ready(input logic fl, input logic ordy);
    if (fl) return 1'b1;
    if (q.size() < CAP) return 1'b1;
    return (CAP == 1) && ordy;
  endfunction

  task automatic check_outputs();
    wb_payload_t h;
    logic        v_exp;
    logic        rw_exp;
    logic [31:0] wb_exp;
    v_exp = (q.size() > 0);
    chk("out_valid", 32'(out_valid), 32'(v_exp));
    if (v_exp) begin
      h      = q[0];
      wb_exp = h.mem_to_reg ? h.read_data : h.alu_result;
      rw_exp = h.reg_write && (h.dest_reg != 5'd0);
      chk("out_read_data", out_read_data, h.read_data);
      chk("out_alu_result", out_alu_result, h.alu_result);
      chk("out_dest_reg", 32'(out_dest_reg), 32'(h.dest_reg));
      chk("out_mem_to_reg", 32'(out_mem_to_reg), 32'(h.mem_to_reg));
      chk("out_wb_data", out_wb_data, wb_exp);
      chk("out_reg_write", 32'(out_reg_write), 32'(rw_exp));
      chk("fwd_valid", 32'(fwd_valid), 32'(rw_exp));
      chk("fwd_reg", 32'(fwd_reg), 32'(h.dest_reg));
      chk("fwd_data", fwd_data, wb_exp);
    end else begin
      chk("out_reg_write_idle", 32'(out_reg_write), 32'd0);
      chk("fwd_valid_idle", 32'(fwd_valid), 32'd0);
    end
  endtask

  // One cycle: drive at negedge, check pre-edge state, clock, advance model
  task automatic step(input logic fl, input logic iv, input logic ordy, input wb_payload_t p);
    logic ir_exp;
    logic push;
    flush         = fl;
    in_valid      = iv;
    out_ready     = ordy;
    in_read_data  = p.read_data;
    in_alu_result = p.alu_result;
    in_dest_reg   = p.dest_reg;
    in_reg_write  = p.reg_write;
    in_mem_to_reg = p.mem_to_reg;
    #1;
    ir_exp = exp_in_ready(fl, ordy);
    chk("in_ready", 32'(in_ready), 32'(ir_exp));
    check_outputs();
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      push = iv && ir_exp;
      if (q.size() > 0 && ordy) q.delete(0);
      if (push) q.push_back(p);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_zero();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_wb_data", out_wb_data, 32'd0);
    chk("rst_out_reg_write", 32'(out_reg_write), 32'd0);
    chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("rst_out_dest_reg", 32'(out_dest_reg), 32'd0);
    chk("rst_out_alu_result", out_alu_result, 32'd0);
  endtask

  wb_payload_t nop;

  initial begin
    nop = mk(32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    tbl[0] = '{1'b0, 1'b1, mk(32'hDEADBEEF, 32'h10, 5'd8, 1'b1, 1'b1), 1'b1, 32'hDEADBEEF, 1'b1, 5'd8};
    tbl[1] = '{1'b0, 1'b1, mk(32'h5555, 32'h1234, 5'd0, 1'b1, 1'b0), 1'b1, 32'h1234, 1'b0, 5'd0};
    tbl[2] = '{1'b0, 1'b1, mk(32'h0, 32'hCAFE, 5'd31, 1'b1, 1'b0), 1'b1, 32'hCAFE, 1'b1, 5'd31};
    tbl[3] = '{1'b0, 1'b1, mk(32'h77, 32'h40, 5'd9, 1'b0, 1'b0), 1'b1, 32'h40, 1'b0, 5'd9};
    tbl[4] = '{1'b0, 1'b0, nop, 1'b0, 32'h0, 1'b0, 5'd0};
    tbl[5] = '{1'b1, 1'b1, mk(32'hBAD, 32'hBAD, 5'd3, 1'b1, 1'b0), 1'b0, 32'h0, 1'b0, 5'd0};

    // Reset before any clock edge
    #1;
    check_reset_zero();
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table with out_ready held high
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].fl, tbl[i].iv, 1'b1, tbl[i].p);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_reg_write", i), 32'(out_reg_write), 32'(tbl[i].erw));
      chk($sformatf("tbl%0d_fwd_valid", i), 32'(fwd_valid), 32'(tbl[i].erw));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_wb_data", i), out_wb_data, tbl[i].ewb);
        chk($sformatf("tbl%0d_fwd_reg", i), 32'(fwd_reg), 32'(tbl[i].edst));
      end
    end

    // Stall three cycles, then release; model tracks order and in_ready per mode
    step(1'b0, 1'b1, 1'b1, mk(32'hA0, 32'hA1, 5'd1, 1'b1, 1'b1));
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0, mk(32'hB0 + 32'(k), 32'hB1, 5'd2, 1'b1, 1'b0));
      chk("stall_wb_data", out_wb_data, 32'hA0);
      chk("stall_dest", 32'(out_dest_reg), 32'd1);
    end
    step(1'b0, 1'b1, 1'b1, mk(32'hC0, 32'hC1, 5'd4, 1'b1, 1'b0));
    step(1'b0, 1'b0, 1'b1, nop);
    step(1'b0, 1'b0, 1'b1, nop);
    step(1'b0, 1'b0, 1'b1, nop);

    // Flush with a stored beat and one incoming, also while stalled with skid full
    step(1'b0, 1'b1, 1'b1, mk(32'hD0, 32'hD1, 5'd5, 1'b1, 1'b0));
    step(1'b1, 1'b1, 1'b1, mk(32'hE0, 32'hE1, 5'd6, 1'b1, 1'b0));
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_fwd_valid", 32'(fwd_valid), 32'd0);
    step(1'b0, 1'b0, 1'b1, nop);
    chk("flush_no_leak", 32'(out_valid), 32'd0);
    step(1'b0, 1'b1, 1'b0, mk(32'h1, 32'h2, 5'd7, 1'b1, 1'b0));
    step(1'b0, 1'b1, 1'b0, mk(32'h3, 32'h4, 5'd7, 1'b1, 1'b0));
    step(1'b1, 1'b1, 1'b0, mk(32'h5, 32'h6, 5'd7, 1'b1, 1'b0));
    chk("flush_stall_valid", 32'(out_valid), 32'd0);
    step(1'b0, 1'b0, 1'b1, nop);

    // Reset asserted mid-stall drops every beat immediately
    step(1'b0, 1'b1, 1'b1, mk(32'hF0, 32'hF1, 5'd10, 1'b1, 1'b1));
    step(1'b0, 1'b1, 1'b0, mk(32'hF2, 32'hF3, 5'd11, 1'b1, 1'b1));
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_zero();
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b1, nop);

    // Back-to-back stream of 8 beats
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b1, mk(32'h0, 32'h100 + 32'(i), 5'd12, 1'b1, 1'b0));
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_wb_data", out_wb_data, 32'h100 + 32'(i));
    end
    step(1'b0, 1'b0, 1'b1, nop);

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      logic [4:0] d;
      d = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31));
      step(($urandom_range(15) == 0), ($urandom_range(3) != 0), ($urandom_range(3) != 0),
           mk($urandom, $urandom, d, 1'($urandom_range(1)), 1'($urandom_range(1))));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_mem_wb_pipe_reg
